// File: rtl/float_mult_pkg.sv
// Shared types and constants for the float16 multiplier scheduler.
// float16 format: [15] sign (1 = positive), [14:10] exponent (bias 16), [9:0] mantissa (value = m/512).
package float_mult_pkg;

    typedef logic [15:0] float16_t;

    localparam float16_t    FLOAT_ONE = 16'hC200;
    localparam float16_t    FLOAT_TWO = 16'hC600;
    localparam int unsigned EXP_BIAS  = 16;

    // Tag id width sized for the largest supported requester count (8).
    localparam int unsigned TAG_IDW = 3;

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/float_mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered search pointer.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic [IDW-1:0] r_ptr;
    logic           w_found;
    logic [IDW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Candidate index is (ptr + k) mod N, without a divider.
            if (32'(r_ptr) + k >= N)
                w_cand = IDW'(32'(r_ptr) + k - N);
            else
                w_cand = IDW'(32'(r_ptr) + k);
            if (en && !w_found && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                gnt_idx     = w_cand;
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (w_found)
            r_ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/float_mult_scheduler.sv
// Shares one fixed-latency float_multiply among N_REQ requesters; results return tagged with requester id.
module float_mult_scheduler
    import float_mult_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned IDW     = $clog2(N_REQ)
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*16-1:0]          req_adata,
    input  logic [N_REQ*16-1:0]          req_bdata,
    input  logic                         hold,
    output float16_t                     mul_adata,
    output float16_t                     mul_bdata,
    input  float16_t                     mul_cdata,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output float16_t                     rsp_data,
    output logic                         busy,
    output logic [$clog2(MUL_LAT+2)-1:0] inflight
);

    localparam int unsigned CNTW = $clog2(MUL_LAT + 2);

    logic [N_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_grant;
    float16_t         w_sel_a;
    float16_t         w_sel_b;
    float16_t         r_mul_a;
    float16_t         r_mul_b;
    tag_t             r_tag [0:MUL_LAT];
    logic [CNTW-1:0]  r_cnt;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .clk     (clock),
        .rst     (rst),
        .req     (req_valid),
        .en      (~hold),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_grant   = |w_gnt;
    assign w_sel_a   = req_adata[32'(w_gnt_idx)*16 +: 16];
    assign w_sel_b   = req_bdata[32'(w_gnt_idx)*16 +: 16];

    always_ff @(posedge clock) begin
        if (rst) begin
            r_mul_a <= FLOAT_ONE;
            r_mul_b <= FLOAT_ONE;
        end else if (w_grant) begin
            r_mul_a <= w_sel_a;
            r_mul_b <= w_sel_b;
        end
    end

    // Tag stage k tracks the op whose operands entered the multiplier k cycles ago.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned k = 0; k <= MUL_LAT; k++)
                r_tag[k] <= '0;
        end else begin
            r_tag[0] <= '{vld: w_grant, id: TAG_IDW'(w_gnt_idx)};
            for (int unsigned k = 1; k <= MUL_LAT; k++)
                r_tag[k] <= r_tag[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (rst)
            r_cnt <= '0;
        else begin
            case ({w_grant, rsp_valid})
                2'b10:   r_cnt <= r_cnt + CNTW'(1);
                2'b01:   r_cnt <= r_cnt - CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign mul_adata = r_mul_a;
    assign mul_bdata = r_mul_b;
    assign rsp_valid = r_tag[MUL_LAT].vld;
    assign rsp_id    = r_tag[MUL_LAT].id[IDW-1:0];
    assign rsp_data  = mul_cdata;
    assign inflight  = r_cnt;
    assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_float_mult_scheduler.sv
// Directed bench for float_mult_scheduler with a behavioural fixed-latency float16 multiplier.
module tb_float_mult_scheduler;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned IDW     = 2;

    logic              clock = 1'b0;
    logic              rst;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ*16-1:0] req_adata;
    logic [N_REQ*16-1:0] req_bdata;
    logic              hold;
    logic [15:0]       mul_adata;
    logic [15:0]       mul_bdata;
    logic [15:0]       mul_cdata;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;
    logic              busy;
    logic [1:0]        inflight;

    int n_checks = 0;
    int n_errors = 0;

    float_mult_scheduler #(
        .N_REQ   (N_REQ),
        .MUL_LAT (MUL_LAT),
        .IDW     (IDW)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adata (req_adata),
        .req_bdata (req_bdata),
        .hold      (hold),
        .mul_adata (mul_adata),
        .mul_bdata (mul_bdata),
        .mul_cdata (mul_cdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .inflight  (inflight)
    );

    always #5 clock = ~clock;

    // Float16 product: mantissas in [512,1024) so the raw product lies in [2^18, 2^20).
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [19:0] p;
        logic [9:0]  m;
        logic [4:0]  e;
        p = 20'(a[9:0]) * 20'(b[9:0]);
        e = 5'(32'(a[14:10]) + 32'(b[14:10]) - 16);
        if (p[19]) begin
            m = p[19:10];
            e = e + 5'd1;
        end else begin
            m = p[18:9];
        end
        return {~(a[15] ^ b[15]), e, m};
    endfunction

    logic [15:0] m_pipe [0:MUL_LAT-1];
    always @(posedge clock) begin
        m_pipe[0] <= fmul(mul_adata, mul_bdata);
        for (int i = 1; i < MUL_LAT; i++)
            m_pipe[i] <= m_pipe[i-1];
    end
    assign mul_cdata = m_pipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_adata[idx*16 +: 16] = a;
        req_bdata[idx*16 +: 16] = b;
    endtask

    initial begin
        int rsp_seen;
        rst       = 1'b1;
        req_valid = '0;
        hold      = 1'b0;
        req_adata = {4{16'hC200}};
        req_bdata = {4{16'hC200}};
        tick();
        tick();
        #1;
        check("rst_mul_a",    32'(mul_adata), 32'hC200);
        check("rst_mul_b",    32'(mul_bdata), 32'hC200);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id",   32'(rsp_id),    0);
        check("rst_busy",     32'(busy),      0);
        check("rst_inflight", 32'(inflight),  0);
        check("rst_ready",    32'(req_ready), 0);
        rst = 1'b0;
        tick();

        // Reset mid-stream: grant requester 1, then reset on the following edge.
        set_ops(1, 16'hC600, 16'hC600);
        req_valid = 4'b0010;
        #1;
        check("mid_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("mid_inflight_pre", 32'(inflight), 1);
        check("mid_mul_a_pre", 32'(mul_adata), 32'hC600);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_inflight", 32'(inflight), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_mul_a", 32'(mul_adata), 32'hC200);
        rsp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) rsp_seen++;
            tick();
        end
        check("mid_no_rsp", 32'(rsp_seen), 0);

        // Single request from requester 2: 1.0 * 2.0.
        set_ops(2, 16'hC200, 16'hC600);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        check("single_inflight", 32'(inflight), 1);
        check("single_busy", 32'(busy), 1);
        check("single_mul_b", 32'(mul_bdata), 32'hC600);
        check("single_rsp_t1", 32'(rsp_valid), 0);
        tick();
        check("single_rsp_t2", 32'(rsp_valid), 0);
        tick();
        check("single_rsp_t3", 32'(rsp_valid), 1);
        check("single_id", 32'(rsp_id), 2);
        check("single_data", 32'(rsp_data), 32'hC600);
        tick();
        check("single_rsp_t4", 32'(rsp_valid), 0);
        check("single_idle", 32'(inflight), 0);

        // All four requesting continuously for 8 cycles after a reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, 16'hC200, 16'hC200);
        for (int k = 0; k < 11; k++) begin
            int exp_inf;
            logic [3:0] exp_rdy;
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            exp_inf = ((k < 8) ? k : 8) - ((k > 3) ? k - 3 : 0);
            check($sformatf("all_ready_%0d", k), 32'(req_ready), 32'(exp_rdy));
            check($sformatf("all_inflight_%0d", k), 32'(inflight), 32'(exp_inf));
            check($sformatf("all_rsp_valid_%0d", k), 32'(rsp_valid), (k >= 3) ? 1 : 0);
            if (k >= 3) begin
                check($sformatf("all_rsp_id_%0d", k), 32'(rsp_id), 32'((k - 3) % 4));
                check($sformatf("all_rsp_data_%0d", k), 32'(rsp_data), 32'hC200);
            end
            tick();
        end
        check("all_drained", 32'(rsp_valid), 0);

        // Pointer after partial use: 2, then {0,2} -> 0, then 2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("ptr_first", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0101;
        #1;
        check("ptr_wrap", 32'(req_ready), 32'h1);
        tick();
        #1;
        check("ptr_next", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        check("ptr_idle", 32'(inflight), 0);

        // Two ops issued (pointer at 3 -> ids 3 then 0), then hold for 5 cycles.
        req_valid = 4'b1111;
        #1;
        check("hold_pre0", 32'(req_ready), 32'h8);
        tick();
        #1;
        check("hold_pre1", 32'(req_ready), 32'h1);
        tick();
        hold = 1'b1;
        for (int h = 0; h < 5; h++) begin
            #1;
            check($sformatf("hold_ready_%0d", h), 32'(req_ready), 0);
            check($sformatf("hold_inflight_%0d", h), 32'(inflight), (h <= 1) ? 2 : (h == 2) ? 1 : 0);
            check($sformatf("hold_rsp_valid_%0d", h), 32'(rsp_valid), (h == 1 || h == 2) ? 1 : 0);
            if (h == 1) check("hold_rsp_id_a", 32'(rsp_id), 3);
            if (h == 2) check("hold_rsp_id_b", 32'(rsp_id), 0);
            tick();
        end
        hold = 1'b0;
        req_valid = '0;
        tick();

        // Operand independence: pointer at 1, so grants alternate 3,0,3,0.
        // 1.5 * 1.5 = 2.25, which encodes as 16'hC640 (exp 17, m = 576).
        set_ops(3, 16'hC300, 16'hC300);
        set_ops(0, 16'hC200, 16'hC200);
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 4) ? 4'b1001 : 4'b0000;
            #1;
            check($sformatf("ind_ready_%0d", k), 32'(req_ready),
                  (k < 4) ? ((k % 2 == 0) ? 32'h8 : 32'h1) : 32'h0);
            if (k >= 3) begin
                check($sformatf("ind_rsp_valid_%0d", k), 32'(rsp_valid), 1);
                check($sformatf("ind_rsp_id_%0d", k), 32'(rsp_id), ((k - 3) % 2 == 0) ? 3 : 0);
                check($sformatf("ind_rsp_data_%0d", k), 32'(rsp_data),
                      ((k - 3) % 2 == 0) ? 32'hC640 : 32'hC200);
            end
            tick();
        end
        check("ind_drained", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
